// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one external full_adder LSB-first and
// assembles the WIDTH-bit sum and final carry over WIDTH SHIFT cycles.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_next;

  // New sum bit enters at the MSB; written as a shift of the concatenation so WIDTH=1 needs no special case.
  assign s_next = WIDTH'({fa_sum, s_reg} >> 1);

  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state == SHIFT) begin
      fa_a   = a_reg[0];
      fa_b   = b_reg[0];
      fa_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            s_reg <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          s_reg <= s_next;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= s_next;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl with a combinational full adder cell, WIDTH=8.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  // External full_adder cell
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    bit           cin_all1;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and follows it to the cycle after done.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       input int poke_at, input bit poke_done,
                       output int lat, output int bcyc, output int dcnt,
                       output bit cin_all1, output bit hold_ok);
    lat = -1; bcyc = 0; dcnt = 0; cin_all1 = 1'b1; hold_ok = 1'b1;
    start = 1'b1; a = oa; b = ob; cin = oc;
    tick();
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i <= W + 4; i++) begin
      if (done) begin
        dcnt = 1;
        lat  = i;
        break;
      end
      if (busy) begin
        bcyc++;
        if (!fa_cin) cin_all1 = 1'b0;
        if (sum !== prev_sum || cout !== prev_cout) hold_ok = 1'b0;
        if (bcyc == poke_at) begin
          start = 1'b1; a = 8'hAA; b = 8'h55;
        end
      end
      tick();
      start = 1'b0;
    end
    if (dcnt == 1) begin
      check("fa_zero_in_done", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
      check("busy_low_in_done", 32'(busy), 32'd0);
      if (poke_done) begin
        start = 1'b1; a = 8'h33; b = 8'h44;
      end
      tick();
      start = 1'b0;
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  int lat, bcyc, dcnt;
  bit cin_all1, hold_ok;
  logic [W:0] golden;
  int extra;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[7] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_after_reset_busy", 32'(busy), 32'd0);
    prev_sum = '0; prev_cout = 1'b0;

    foreach (vecs[k]) begin
      do_op(vecs[k].a, vecs[k].b, vecs[k].cin, 0, 1'b0, lat, bcyc, dcnt, cin_all1, hold_ok);
      check($sformatf("vec%0d_done", k), 32'(dcnt), 32'd1);
      check($sformatf("vec%0d_sum", k), 32'(sum), 32'(vecs[k].s));
      check($sformatf("vec%0d_cout", k), 32'(cout), 32'(vecs[k].c));
      check($sformatf("vec%0d_start_to_done_edges", k), 32'(lat + 1), 32'(W + 1));
      check($sformatf("vec%0d_busy_cycles", k), 32'(bcyc), 32'(W));
      check($sformatf("vec%0d_hold", k), 32'(hold_ok), 32'd1);
      if (vecs[k].cin_all1) check($sformatf("vec%0d_fa_cin_all1", k), 32'(cin_all1), 32'd1);
      prev_sum = vecs[k].s; prev_cout = vecs[k].c;
    end

    // start pulse during SHIFT cycle 3 must be ignored
    do_op(8'h10, 8'h20, 1'b0, 3, 1'b0, lat, bcyc, dcnt, cin_all1, hold_ok);
    check("poke_shift_done", 32'(dcnt), 32'd1);
    check("poke_shift_sum", 32'(sum), 32'h30);
    check("poke_shift_cout", 32'(cout), 32'd0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) extra++;
      tick();
    end
    check("poke_shift_no_second_op", 32'(extra), 32'd0);
    prev_sum = 8'h30; prev_cout = 1'b0;

    // start during the DONE cycle must be ignored
    do_op(8'h21, 8'h43, 1'b1, 0, 1'b1, lat, bcyc, dcnt, cin_all1, hold_ok);
    check("poke_done_sum", 32'(sum), 32'h65);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) extra++;
      tick();
    end
    check("poke_done_no_new_op", 32'(extra), 32'd0);
    check("poke_done_sum_held", 32'(sum), 32'h65);
    prev_sum = 8'h65; prev_cout = 1'b0;

    // reset at SHIFT cycle 4 aborts the add
    start = 1'b1; a = 8'h81; b = 8'h81; cin = 1'b0;
    tick();
    start = 1'b0;
    bcyc = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (busy) bcyc++;
      if (bcyc == 4) break;
      tick();
    end
    check("abort_reached_shift4", 32'(bcyc), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) extra++;
      tick();
    end
    check("abort_no_done", 32'(extra), 32'd0);
    prev_sum = '0; prev_cout = 1'b0;
    do_op(8'h01, 8'h02, 1'b0, 0, 1'b0, lat, bcyc, dcnt, cin_all1, hold_ok);
    check("after_abort_done", 32'(dcnt), 32'd1);
    check("after_abort_sum", 32'(sum), 32'h03);
    prev_sum = 8'h03; prev_cout = 1'b0;

    // back-to-back random operations at minimum issue interval
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      golden = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, 0, 1'b0, lat, bcyc, dcnt, cin_all1, hold_ok);
      check($sformatf("rand%0d_result", n), {23'd0, cout, sum}, 32'(golden));
      check($sformatf("rand%0d_timing", n), {30'd0, 1'(dcnt == 1 && lat == W), hold_ok}, 32'd3);
      prev_sum = golden[W-1:0]; prev_cout = golden[W];
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
